seg_add_sub: RTL and testbench

//   Multi-cycle, parametrised add/subtract unit with carry (C) and overflow (V) flags.

---
 rtl/seg_add_sub.sv | 154 +++++++++++++++
 tb/tb_seg_add_sub.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_add_sub.sv
// seg_add_sub: multi-cycle add/subtract unit processing SEG_WIDTH bits per
// cycle, least-significant segment first, with valid/ready on both sides.
// Optional feature macro: SEG_FLAGS_ZN_EN adds registered zero (z) and
// negative (n) flags alongside the carry (c) and overflow (v) flags.
module seg_add_sub #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             m_0_x,
  input  logic             m_sub_add,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             v
`ifdef SEG_FLAGS_ZN_EN
  ,
  output logic             z,
  output logic             n
`endif
);

  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 sub_q, sub_d;
  logic [WIDTH-1:0]     ax_q, ax_d;
  logic [WIDTH-1:0]     ay_q, ay_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 c_q, c_d;
  logic                 v_q, v_d;
`ifdef SEG_FLAGS_ZN_EN
  logic                 z_q, z_d;
  logic                 n_q, n_d;
`endif
  logic                 accept;
  logic                 last_seg;
  logic [SEG_WIDTH:0]   seg_res;

  assign last_seg = (cnt_q == CW'(NSEG - 1));
  assign sum      = sum_q;
  assign c        = c_q;
  assign v        = v_q;
`ifdef SEG_FLAGS_ZN_EN
  assign z        = z_q;
  assign n        = n_q;
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      ax_q    <= '0;
      ay_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef SEG_FLAGS_ZN_EN
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      v_q     <= v_d;
`ifdef SEG_FLAGS_ZN_EN
      z_q     <= z_d;
      n_q     <= n_d;
`endif
    end
  end

  // Next-state logic: DONE can hand straight back to BUSY on a same-cycle accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_seg) state_d = DONE;
      DONE: begin
        if (accept)         state_d = BUSY;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    out_valid = (state_q == DONE);
    accept    = in_valid & in_ready;
  end

  // Operand capture on accept, one segment of ripple addition per BUSY cycle
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    sum_d   = sum_q;
    c_d     = c_q;
    v_d     = v_q;
`ifdef SEG_FLAGS_ZN_EN
    z_d     = z_q;
    n_d     = n_q;
`endif
    seg_res = {1'b0, ax_q[cnt_q*SEG_WIDTH +: SEG_WIDTH]}
            + {1'b0, ay_q[cnt_q*SEG_WIDTH +: SEG_WIDTH]}
            + (SEG_WIDTH+1)'(carry_q);
    if (accept) begin
      // Subtraction is X + ~Y + 1: the +1 enters as the initial carry
      ax_d    = m_0_x ? '0 : x;
      ay_d    = y ^ {WIDTH{m_sub_add}};
      carry_d = m_sub_add;
      sub_d   = m_sub_add;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      sum_d[cnt_q*SEG_WIDTH +: SEG_WIDTH] = seg_res[SEG_WIDTH-1:0];
      carry_d = seg_res[SEG_WIDTH];
      cnt_d   = cnt_q + CW'(1);
      if (last_seg) begin
        c_d = seg_res[SEG_WIDTH] ^ sub_q;
        v_d = (~ax_q[WIDTH-1] & ~ay_q[WIDTH-1] &  sum_d[WIDTH-1]) |
              ( ax_q[WIDTH-1] &  ay_q[WIDTH-1] & ~sum_d[WIDTH-1]);
`ifdef SEG_FLAGS_ZN_EN
        z_d = ~|sum_d;
        n_d = sum_d[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg_add_sub.sv
// Scoreboard bench for seg_add_sub: a 32/8 instance (4 segments) and a
// 16/16 instance (single segment). Expected results come from a plain
// arithmetic model; monitors pop and compare on every output handshake.
module tb_seg_add_sub;

  localparam int W0 = 32, S0 = 8,  N0 = W0 / S0;
  localparam int W1 = 16, S1 = 16, N1 = W1 / S1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, m_0_x, m_sub_add, out_valid, out_ready, c, v;
  logic [W0-1:0] x, y, sum;
  logic          in_valid1, in_ready1, m_0_x1, m_sub_add1, out_valid1, out_ready1, c1, v1;
  logic [W1-1:0] x1, y1, sum1;
`ifdef SEG_FLAGS_ZN_EN
  logic          z, n, z1, n1;
`endif

  seg_add_sub #(.WIDTH(W0), .SEG_WIDTH(S0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .m_0_x(m_0_x), .m_sub_add(m_sub_add),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c(c), .v(v)
`ifdef SEG_FLAGS_ZN_EN
    , .z(z), .n(n)
`endif
  );

  seg_add_sub #(.WIDTH(W1), .SEG_WIDTH(S1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .x(x1), .y(y1), .m_0_x(m_0_x1), .m_sub_add(m_sub_add1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .c(c1), .v(v1)
`ifdef SEG_FLAGS_ZN_EN
    , .z(z1), .n(n1)
`endif
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        c, v, z, n;
  } exp_t;

  exp_t exp_q[$], exp1_q[$];
  int   acc_q[$], acc1_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   lat_done = 1'b0, lat1_done = 1'b0;
  bit   rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (no response within bound / unexpected output)", name);
  endtask

  // Reference: whole-word arithmetic, carry = unsigned out-of-range, v = signed overflow
  function automatic exp_t model(input int w, input logic [31:0] xv, input logic [31:0] yv,
                                 input logic m0v, input logic subv);
    exp_t            e;
    longint unsigned mask, ax, yy, full;
    logic            sa, sy, ss;
    mask  = (64'd1 << w) - 64'd1;
    ax    = m0v ? 64'd0 : {32'd0, xv};
    yy    = {32'd0, yv};
    full  = subv ? (ax - yy) : (ax + yy);
    e.sum = 32'(full & mask);
    e.c   = subv ? (ax < yy) : full[w];
    sa    = ax[w-1];
    sy    = yy[w-1];
    ss    = full[w-1];
    e.v   = subv ? ((sa != sy) && (ss != sa)) : ((sa == sy) && (ss != sa));
    e.z   = (e.sum == 32'd0);
    e.n   = ss;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver, updated slightly after the stimulus so it sees rdy_force changes
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor for the 4-segment instance
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat_done = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !lat_done) begin
        lat_done = 1'b1;
        if (acc_q.size() == 0) fail_now("latency0_no_accept");
        else chk("latency0", cyc - acc_q.pop_front(), N0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result0");
        else begin
          e = exp_q.pop_front();
          chk("sum0", sum, e.sum);
          chk("c0", c, e.c);
          chk("v0", v, e.v);
`ifdef SEG_FLAGS_ZN_EN
          chk("z0", z, e.z);
          chk("n0", n, e.n);
`endif
        end
        lat_done = 1'b0;
      end
    end
  end

  // Monitor for the single-segment instance
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat1_done = 1'b0;
    end else begin
      if (in_valid1 && in_ready1) acc1_q.push_back(cyc + 1);
      if (out_valid1 && !lat1_done) begin
        lat1_done = 1'b1;
        if (acc1_q.size() == 0) fail_now("latency1_no_accept");
        else chk("latency1", cyc - acc1_q.pop_front(), N1);
      end
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) fail_now("unexpected_result1");
        else begin
          e = exp1_q.pop_front();
          chk("sum1", {16'd0, sum1}, e.sum);
          chk("c1", c1, e.c);
          chk("v1", v1, e.v);
`ifdef SEG_FLAGS_ZN_EN
          chk("z1", z1, e.z);
          chk("n1", n1, e.n);
`endif
        end
        lat1_done = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic m0v, input logic subv);
    int n = 0;
    bit acc = 1'b0;
    x = xv; y = yv; m_0_x = m0v; m_sub_add = subv; in_valid = 1'b1;
    exp_q.push_back(model(W0, xv, yv, m0v, subv));
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    x = $urandom; y = $urandom; m_0_x = 1'($urandom); m_sub_add = 1'($urandom);
    if (!acc) fail_now("send0_timeout");
  endtask

  task automatic send1(input logic [15:0] xv, input logic [15:0] yv, input logic m0v, input logic subv);
    int n = 0;
    bit acc = 1'b0;
    x1 = xv; y1 = yv; m_0_x1 = m0v; m_sub_add1 = subv; in_valid1 = 1'b1;
    exp1_q.push_back(model(W1, {16'd0, xv}, {16'd0, yv}, m0v, subv));
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid1 = 1'b0;
    x1 = 16'($urandom); y1 = 16'($urandom);
    if (!acc) fail_now("send1_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || exp1_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) fail_now("wait_out_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t h;
    rst = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; m_0_x = 1'b0; m_sub_add = 1'b0;
    in_valid1 = 1'b0; x1 = '0; y1 = '0; m_0_x1 = 1'b0; m_sub_add1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sum", sum, 32'h0);
    chk("rst_c", c, 1'b0);
    chk("rst_v", v, 1'b0);
`ifdef SEG_FLAGS_ZN_EN
    chk("rst_z", z, 1'b0);
    chk("rst_n", n, 1'b0);
`endif

    // Directed corner operations, back-to-back with out_ready held high
    rdy_rand = 1'b0; rdy_force = 1'b1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1);
    send(32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 1'b1);
    drain();

    // Result held while the consumer stalls, then back-to-back accept on release
    rdy_force = 1'b0;
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    h = model(W0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_sum", sum, h.sum);
      chk("hold_c", c, h.c);
      chk("hold_v", v, h.v);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    drain();

    // Reset mid-operation at segment 2 aborts without a result
    send(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_sum", sum, 32'h0);
    chk("abort_c", c, 1'b0);
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
    drain();

    // Randomized traffic with random consumer back-pressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(pick(), pick(), ($urandom_range(0, 7) == 0), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_rand = 1'b0; rdy_force = 1'b1;
    drain();

    // Single-segment instance
    send1(16'h8000, 16'h8000, 1'b0, 1'b0);
    send1(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send1(16'h0001, 16'h0002, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send1(16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
